// File: rtl/deth_nms_3x3.sv
// Streaming 3x3 non-maximum suppression on the raster-ordered Hessian determinant stream.
// Emits one record per interior pixel above threshold that strictly dominates its 8 neighbours.
module deth_nms_3x3 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_sof,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic                  kp_valid,
    output logic [X_W-1:0]        kp_x,
    output logic [Y_W-1:0]        kp_y,
    output logic [DATA_WIDTH-1:0] kp_d,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      kp_cnt
);

    localparam logic [X_W-1:0] LAST_COL = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] LAST_ROW = Y_W'(IMG_H - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    logic signed [DATA_WIDTH-1:0] din_s;
    logic [X_W-1:0]               col;
    logic [Y_W-1:0]               row;
    logic [X_W-1:0]               col_p0;
    logic [Y_W-1:0]               row_p0;
    logic                         sof_p0;
    logic                         frame_start_p0;
    logic                         last_p0;
    logic signed [DATA_WIDTH-1:0] lb1 [IMG_W];
    logic signed [DATA_WIDTH-1:0] lb2 [IMG_W];
    logic signed [DATA_WIDTH-1:0] lb1_rd_p0;
    logic signed [DATA_WIDTH-1:0] lb2_rd_p0;
    logic signed [DATA_WIDTH-1:0] thresh_q;

    logic signed [DATA_WIDTH-1:0] win_p1 [3][3];
    logic                         vld_p1;
    logic                         last_p1;
    logic [X_W-1:0]               col_p1;
    logic [Y_W-1:0]               row_p1;
    logic signed [DATA_WIDTH-1:0] centre_p1;
    logic                         dom_p1;
    logic                         hit_p1;

    assign din_s = din;

    // Stage 0: a sof beat is pixel (0,0) no matter where the counters stand.
    assign sof_p0         = din_valid && din_sof;
    assign col_p0         = sof_p0 ? '0 : col;
    assign row_p0         = sof_p0 ? '0 : row;
    assign frame_start_p0 = din_valid && (col_p0 == '0) && (row_p0 == '0);
    assign last_p0        = din_valid && (col_p0 == LAST_COL) && (row_p0 == LAST_ROW);
    assign lb1_rd_p0      = lb1[col_p0];
    assign lb2_rd_p0      = lb2[col_p0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            thresh_q <= '0;
        end else if (din_valid) begin
            if (col_p0 == LAST_COL) begin
                col <= '0;
                row <= (row_p0 == LAST_ROW) ? '0 : row_p0 + Y_W'(1);
            end else begin
                col <= col_p0 + X_W'(1);
                row <= row_p0;
            end
            if (frame_start_p0)
                thresh_q <= din_s;
            if (frame_start_p0)
                thresh_q <= thresh;
        end
    end

    // Line buffers are never reset: rows 0 and 1 cannot produce candidates.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb1[col_p0] <= din_s;
            lb2[col_p0] <= lb1_rd_p0;
        end
    end

    // Stage 1: window shifts left one column per beat; new right column is rows r-2, r-1, r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p1[r][c] <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            col_p1  <= '0;
            row_p1  <= '0;
        end else begin
            vld_p1  <= din_valid;
            last_p1 <= last_p0;
            if (din_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_p1[r][0] <= win_p1[r][1];
                    win_p1[r][1] <= win_p1[r][2];
                end
                win_p1[0][2] <= lb2_rd_p0;
                win_p1[1][2] <= lb1_rd_p0;
                win_p1[2][2] <= din_s;
                col_p1       <= col_p0;
                row_p1       <= row_p0;
            end
        end
    end

    always_comb begin
        centre_p1 = win_p1[1][1];
        dom_p1    = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!(r == 1 && c == 1) && !(centre_p1 > win_p1[r][c]))
                    dom_p1 = 1'b0;
    end

    // Beat column/row >= 2 keeps the centre off row 0 and column 0; the far borders
    // are excluded because the centre always trails the beat by one line and one column.
    assign hit_p1 = vld_p1 && (col_p1 >= X_W'(2)) && (row_p1 >= Y_W'(2))
                    && dom_p1 && (centre_p1 > thresh_q);

    // Stage 2: registered keypoint record, frame strobe and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kp_valid   <= 1'b0;
            kp_x       <= '0;
            kp_y       <= '0;
            kp_d       <= '0;
            frame_done <= 1'b0;
            kp_cnt     <= '0;
        end else begin
            kp_valid   <= hit_p1;
            frame_done <= vld_p1 && last_p1;
            if (hit_p1) begin
                kp_x <= col_p1 - X_W'(1);
                kp_y <= row_p1 - Y_W'(1);
                kp_d <= centre_p1;
            end
            kp_cnt <= sat_inc(frame_start_p0 ? '0 : kp_cnt, hit_p1);
        end
    end

endmodule

// File: tb/tb_deth_nms_3x3.sv
// Directed bench for deth_nms_3x3 on an 8x6 image with hand-computed keypoint records.
module tb_deth_nms_3x3;

    localparam int DW = 32;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_sof = 1'b0;
    logic [DW-1:0] thresh = '0;
    logic          kp_valid;
    logic [XW-1:0] kp_x;
    logic [YW-1:0] kp_y;
    logic [DW-1:0] kp_d;
    logic          frame_done;
    logic [CW-1:0] kp_cnt;

    deth_nms_3x3 #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .X_W(XW), .Y_W(YW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .din_sof(din_sof),
        .thresh(thresh), .kp_valid(kp_valid), .kp_x(kp_x), .kp_y(kp_y), .kp_d(kp_d),
        .frame_done(frame_done), .kp_cnt(kp_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int img [H][W];
    int beat_cyc [H][W];
    int nvec = 0;
    int nerr = 0;

    int kp_n = 0;
    int kp_x_r [16];
    int kp_y_r [16];
    int kp_d_r [16];
    int kp_c_r [16];
    int fd_n = 0;
    int fd_c_r [8];
    int fd_k_r [8];

    always @(negedge clk) begin
        if (kp_valid === 1'b1 && kp_n < 16) begin
            kp_x_r[kp_n] = int'(kp_x);
            kp_y_r[kp_n] = int'(kp_y);
            kp_d_r[kp_n] = int'(kp_d);
            kp_c_r[kp_n] = cyc;
            kp_n = kp_n + 1;
        end
        if (frame_done === 1'b1 && fd_n < 8) begin
            fd_c_r[fd_n] = cyc;
            fd_k_r[fd_n] = int'(kp_cnt);
            fd_n = fd_n + 1;
        end
    end

    task automatic clear_img(input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = v;
    endtask

    task automatic clear_log();
        kp_n = 0;
        fd_n = 0;
    endtask

    task automatic drive_pixels(input int start, input int npix, input int gap, input bit sof);
        for (int i = start; i < start + npix; i++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din       = img[i / W][i % W];
            din_sof   = sof && (i == start);
            beat_cyc[i / W][i % W] = cyc;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                din_valid = 1'b0;
                din_sof   = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        din_valid = 1'b0;
        din_sof   = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nvec++; if (kp_valid !== 1'b0) begin nerr++; $display("FAIL reset_kp_valid: got %0b expected 0", kp_valid); end
        nvec++; if (kp_x !== '0) begin nerr++; $display("FAIL reset_kp_x: got %0d expected 0", kp_x); end
        nvec++; if (kp_y !== '0) begin nerr++; $display("FAIL reset_kp_y: got %0d expected 0", kp_y); end
        nvec++; if (kp_d !== '0) begin nerr++; $display("FAIL reset_kp_d: got %0d expected 0", kp_d); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
        nvec++; if (kp_cnt !== '0) begin nerr++; $display("FAIL reset_kp_cnt: got %0d expected 0", kp_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_peak(input int gap, input string tag);
        clear_img(0);
        img[2][3] = 100;
        thresh = 32'(10);
        clear_log();
        drive_pixels(0, W * H, gap, 1'b1);
        idle(6);
        nvec++; if (kp_n !== 1) begin nerr++; $display("FAIL %s_kp_count: got %0d expected 1", tag, kp_n); end
        nvec++; if (kp_x_r[0] !== 3 || kp_y_r[0] !== 2) begin nerr++; $display("FAIL %s_kp_xy: got (%0d,%0d) expected (3,2)", tag, kp_x_r[0], kp_y_r[0]); end
        nvec++; if (kp_d_r[0] !== 100) begin nerr++; $display("FAIL %s_kp_d: got %0d expected 100", tag, kp_d_r[0]); end
        nvec++; if (kp_c_r[0] !== beat_cyc[3][4] + 2) begin nerr++; $display("FAIL %s_kp_latency: got cycle %0d expected %0d", tag, kp_c_r[0], beat_cyc[3][4] + 2); end
        nvec++; if (fd_n !== 1) begin nerr++; $display("FAIL %s_fd_count: got %0d expected 1", tag, fd_n); end
        nvec++; if (fd_c_r[0] !== beat_cyc[5][7] + 2) begin nerr++; $display("FAIL %s_fd_latency: got cycle %0d expected %0d", tag, fd_c_r[0], beat_cyc[5][7] + 2); end
        nvec++; if (kp_cnt !== 16'd1) begin nerr++; $display("FAIL %s_kp_cnt: got %0d expected 1", tag, kp_cnt); end
    endtask

    task automatic test_tie_threshold();
        clear_img(0);
        img[2][3] = 100;
        img[2][4] = 100;
        thresh = 32'(10);
        clear_log();
        drive_pixels(0, W * H, 0, 1'b1);
        idle(6);
        nvec++; if (kp_n !== 0) begin nerr++; $display("FAIL tie_kp_count: got %0d expected 0", kp_n); end
        clear_img(0);
        img[2][3] = 10;
        clear_log();
        drive_pixels(0, W * H, 0, 1'b1);
        idle(6);
        nvec++; if (kp_n !== 0) begin nerr++; $display("FAIL thresh_equal_kp_count: got %0d expected 0", kp_n); end
        img[2][3] = 11;
        clear_log();
        drive_pixels(0, W * H, 0, 1'b1);
        idle(6);
        nvec++; if (kp_n !== 1) begin nerr++; $display("FAIL thresh_above_kp_count: got %0d expected 1", kp_n); end
        nvec++; if (kp_d_r[0] !== 11) begin nerr++; $display("FAIL thresh_above_kp_d: got %0d expected 11", kp_d_r[0]); end
    endtask

    task automatic test_border_negative();
        clear_img(0);
        img[2][0] = 500;
        img[2][7] = 500;
        img[0][3] = 500;
        img[5][3] = 500;
        thresh = 32'(10);
        clear_log();
        drive_pixels(0, W * H, 0, 1'b1);
        idle(6);
        nvec++; if (kp_n !== 0) begin nerr++; $display("FAIL border_kp_count: got %0d expected 0", kp_n); end
        clear_img(-50);
        img[2][3] = -1;
        thresh = 32'(-5);
        clear_log();
        drive_pixels(0, W * H, 0, 1'b1);
        idle(6);
        nvec++; if (kp_n !== 1) begin nerr++; $display("FAIL negative_kp_count: got %0d expected 1", kp_n); end
        nvec++; if (kp_d_r[0] !== -1 || kp_x_r[0] !== 3 || kp_y_r[0] !== 2) begin
            nerr++; $display("FAIL negative_kp_rec: got (%0d,%0d,%0d) expected (3,2,-1)", kp_x_r[0], kp_y_r[0], kp_d_r[0]);
        end
    endtask

    task automatic test_abort();
        clear_img(0);
        thresh = 32'(10);
        clear_log();
        drive_pixels(0, 3 * W + 5, 0, 1'b1);
        img[2][3] = 100;
        drive_pixels(0, W * H, 0, 1'b1);
        idle(6);
        nvec++; if (fd_n !== 1) begin nerr++; $display("FAIL abort_fd_count: got %0d expected 1", fd_n); end
        nvec++; if (fd_c_r[0] !== beat_cyc[5][7] + 2) begin nerr++; $display("FAIL abort_fd_latency: got cycle %0d expected %0d", fd_c_r[0], beat_cyc[5][7] + 2); end
        nvec++; if (kp_n !== 1 || kp_x_r[0] !== 3 || kp_y_r[0] !== 2 || kp_d_r[0] !== 100) begin
            nerr++; $display("FAIL abort_kp_rec: got n=%0d (%0d,%0d,%0d) expected n=1 (3,2,100)", kp_n, kp_x_r[0], kp_y_r[0], kp_d_r[0]);
        end
        nvec++; if (kp_c_r[0] !== beat_cyc[3][4] + 2) begin nerr++; $display("FAIL abort_kp_latency: got cycle %0d expected %0d", kp_c_r[0], beat_cyc[3][4] + 2); end
        nvec++; if (kp_cnt !== 16'd1) begin nerr++; $display("FAIL abort_kp_cnt: got %0d expected 1", kp_cnt); end
    endtask

    task automatic test_mid_reset();
        clear_img(0);
        img[2][3] = 100;
        thresh = 32'(10);
        clear_log();
        drive_pixels(0, 3 * W + 5, 0, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        nvec++; if (kp_valid !== 1'b0 || frame_done !== 1'b0) begin nerr++; $display("FAIL midrst_strobes: got kp_valid=%0b frame_done=%0b expected 0 0", kp_valid, frame_done); end
        nvec++; if (kp_x !== '0 || kp_y !== '0 || kp_d !== '0) begin nerr++; $display("FAIL midrst_rec: got (%0d,%0d,%0d) expected (0,0,0)", kp_x, kp_y, kp_d); end
        nvec++; if (kp_cnt !== '0) begin nerr++; $display("FAIL midrst_kp_cnt: got %0d expected 0", kp_cnt); end
        rst_n = 1'b1;
        idle(3);
        nvec++; if (kp_n !== 0) begin nerr++; $display("FAIL midrst_dropped: got %0d keypoints expected 0", kp_n); end
        drive_pixels(0, W * H, 0, 1'b0);
        idle(6);
        nvec++; if (kp_n !== 1 || kp_x_r[0] !== 3 || kp_y_r[0] !== 2 || kp_d_r[0] !== 100) begin
            nerr++; $display("FAIL midrst_next_frame: got n=%0d (%0d,%0d,%0d) expected n=1 (3,2,100)", kp_n, kp_x_r[0], kp_y_r[0], kp_d_r[0]);
        end
        nvec++; if (fd_n !== 1 || fd_c_r[0] !== beat_cyc[5][7] + 2) begin nerr++; $display("FAIL midrst_fd: got n=%0d cycle %0d expected n=1 cycle %0d", fd_n, fd_c_r[0], beat_cyc[5][7] + 2); end
    endtask

    task automatic test_counter();
        clear_img(0);
        img[1][1] = 20;
        img[1][5] = 30;
        img[3][2] = 40;
        img[4][6] = 50;
        thresh = 32'(10);
        clear_log();
        drive_pixels(0, W * H, 0, 1'b1);
        idle(6);
        nvec++; if (kp_n !== 4) begin nerr++; $display("FAIL counter_kp_events: got %0d expected 4", kp_n); end
        nvec++; if (fd_k_r[0] !== 4) begin nerr++; $display("FAIL counter_at_fd: got %0d expected 4", fd_k_r[0]); end
        nvec++; if (kp_cnt !== 16'd4) begin nerr++; $display("FAIL counter_hold: got %0d expected 4", kp_cnt); end
        clear_img(0);
        clear_log();
        drive_pixels(0, 1, 0, 1'b1);
        idle(2);
        nvec++; if (kp_cnt !== '0) begin nerr++; $display("FAIL counter_clear: got %0d expected 0", kp_cnt); end
        drive_pixels(1, W * H - 1, 0, 1'b0);
        idle(6);
        nvec++; if (fd_n !== 1 || fd_k_r[0] !== 0) begin nerr++; $display("FAIL counter_empty_frame: got n=%0d cnt=%0d expected n=1 cnt=0", fd_n, fd_k_r[0]); end
        nvec++; if (kp_cnt !== '0) begin nerr++; $display("FAIL counter_final: got %0d expected 0", kp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_peak(0, "single");
        test_tie_threshold();
        test_border_negative();
        test_single_peak(2, "gapped");
        test_abort();
        test_mid_reset();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/deth_nms_3x3.md
# detH_nms_3x3

Streaming 3x3 non-maximum suppression stage that sits directly downstream of the Hessian determinant stage. It consumes the raster-ordered detH stream (`din`/`din_valid`), buffers two image lines, and emits a keypoint record for every interior pixel whose determinant exceeds a runtime threshold and strictly dominates its 8 spatial neighbours. It also provides a per-frame keypoint count and an end-of-frame pulse for the descriptor/readout logic.

## Interface
- `DATA_WIDTH`, 32, width of the signed two's-complement detH sample
- `IMG_W`, 640, pixels per line (≥ 3)
- `IMG_H`, 480, lines per frame (≥ 3)
- `X_W`, 10, column coordinate width (2^X_W ≥ IMG_W)
- `Y_W`, 9, row coordinate width (2^Y_W ≥ IMG_H)
- `CNT_W`, 16, keypoint counter width
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `din_valid`  in  1  qualifies `din`/`din_sof`; no backpressure
- `din`  in  DATA_WIDTH  signed detH sample
- `din_sof`  in  1  first pixel of a frame; sampled only with `din_valid`
- `thresh`  in  DATA_WIDTH  signed threshold; sampled at each frame start
- `kp_valid`  out  1  one-cycle keypoint strobe
- `kp_x`  out  X_W  keypoint column
- `kp_y`  out  Y_W  keypoint row
- `kp_d`  out  DATA_WIDTH  keypoint detH value
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame
- `kp_cnt`  out  CNT_W  keypoints found in the current/last frame

## Operation
- Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `din_valid` beats. `col` wraps to 0 and increments `row`. After (IMG_W-1, IMG_H-1), both wrap to 0, which starts a new frame.
- A beat with `din_sof`=1 forces that pixel to (0,0) regardless of counter state and aborts any partial frame. No `frame_done` is issued for an aborted frame.
- Two line buffers of depth IMG_W store rows r-1 and r-2. Each beat reads column `col` from both buffers and writes `din` and the row-1 value. Line buffer contents are not reset; stale data is never used because rows 0 and 1 produce no candidates.
- A 3x3 window of registers shifts left by one column per beat. On the beat at (col,row) with col≥2 and row≥2, the window centre is pixel (col-1,row-1).
- Keypoint condition (all signed):
  - centre > `thresh`, and
  - centre > each of the 8 neighbours. Ties disqualify.
- Border pixels are never reported: row 0, row IMG_H-1, column 0 and column IMG_W-1.
- On a keypoint:
  - `kp_x`=col-1, `kp_y`=row-1, `kp_d`=centre.
  - `kp_cnt` increments and saturates at 2^CNT_W-1.
- `kp_cnt` clears to 0 on the first pixel of each frame (sof or wrap). It then holds its final value after `frame_done` until the next frame starts.
- `thresh` is latched into an internal register on each frame-start pixel. Changes mid-frame take effect at the next frame.
- Reset values:
  - `kp_valid`=0, `kp_x`=0, `kp_y`=0, `kp_d`=0, `frame_done`=0, `kp_cnt`=0.
  - Counters=0 and window registers=0.
  - Latched threshold=0.

## Timing
- Pipeline: stage 1 registers the window and line buffer reads; stage 2 performs the compare and registers the outputs.
- `kp_valid` asserts exactly 2 clocks after the `din_valid` beat at (x+1, y+1) that completes the window for pixel (x,y). `kp_x`/`kp_y`/`kp_d` are valid in the same cycle.
- `frame_done` asserts 2 clocks after the beat at (IMG_W-1, IMG_H-1), coincident with any final `kp_valid`.
- Latency is counted in clocks, not beats. A gap in `din_valid` after a completing beat does not delay its output. Outputs are strobes and are not held.
- Maximum throughput is one pixel per clock with continuous `din_valid`.
- Reset asserted mid-frame: outputs go to their reset values on the next edge, in-flight pipeline strobes are dropped, and the next pixel is treated as (0,0).
- `din_sof` mid-line: pipeline strobes already in flight from the old frame still emerge. `kp_cnt` clears with the sof beat. Old-frame strobes arriving after the clear increment the new count; this is accepted behaviour.

## Test plan
- Single peak, IMG_W=8, IMG_H=6, thresh=10: all zeros except (3,2)=100, streamed continuously → exactly one `kp_valid` with x=3, y=2, d=100, 2 clocks after beat (4,3); `kp_cnt`=1; `frame_done` 2 clocks after beat (7,5).
- Tie and threshold: (3,2)=(4,2)=100 → no keypoint. Separately, (3,2)=10 with thresh=10 → no keypoint. (3,2)=11 → keypoint.
- Border and negative values: peaks of 500 at (0,2), (7,2), (3,0), (3,5) → no keypoints. A frame of all -50 with centre (3,2)=-1 and thresh=-5 → one keypoint, d=-1.
- Gapped input: same stimulus as the single-peak test with `din_valid` toggling 1,0,0,1… → same single keypoint, emitted 2 clocks after its completing beat.
- Abort/resync: assert `din_sof` at (5,3) of frame 1, then send a full single-peak frame → no `frame_done` for frame 1; frame 2 output identical to the single-peak test. Mid-frame `rst_n`=0 for 1 clock → all outputs 0 next cycle, and the next frame processes correctly.
- Counter: frame with 4 isolated peaks, followed by a frame with none → `kp_cnt` reads 4 after the first `frame_done`, then 0 from the second frame's first pixel onward.
